// File: rtl/cell_word_packer.sv
// Packs the loader's one-bit-per-cell stream into WORD_W-bit words
// and hands them to the world-memory writer through a 2-entry FIFO.
module cell_word_packer #(
  parameter int P_PARAM_W = 800,
  parameter int P_PARAM_H = 600,
  parameter int WORD_W    = 32,
  parameter int ADDR_W    = 24
) (
  input  logic              clk_ram,
  input  logic              reset,
  input  logic              bit_wren,
  input  logic              bit_data,
  input  logic [ADDR_W-1:0] bit_addr,
  input  logic              load_finish,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [ADDR_W-1:0] word_addr,
  output logic [WORD_W-1:0] word_data,
  output logic              load_done,
  output logic              overflow,
  output logic              seq_error
);

  localparam int LOG   = $clog2(WORD_W);
  localparam int CELLS = P_PARAM_W * P_PARAM_H;

  localparam logic [ADDR_W-1:0] CELLS_A = ADDR_W'(CELLS);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(CELLS - 1);
  localparam logic [LOG-1:0]    TOP_B   = LOG'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] exp_q, exp_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic              part_q, part_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic              ovf_q, ovf_d;
  logic              seq_q, seq_d;

  logic [ADDR_W-1:0] f_addr_q [2];
  logic [ADDR_W-1:0] f_addr_d [2];
  logic [WORD_W-1:0] f_data_q [2];
  logic [WORD_W-1:0] f_data_d [2];
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              push;
  logic              push_ok;
  logic              pop;
  logic              full;
  logic [ADDR_W-1:0] push_addr;
  logic [WORD_W-1:0] push_data;
  logic [ADDR_W-1:0] cur_addr;
  logic [WORD_W-1:0] acc_w;

  assign pop  = (cnt_q != 2'd0) && word_ready;
  assign full = (cnt_q == 2'd2);

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    acc_d     = acc_q;
    part_d    = part_q;
    wa_d      = wa_q;
    ovf_d     = ovf_q;
    seq_d     = seq_q;
    push      = 1'b0;
    push_addr = '0;
    push_data = '0;
    cur_addr  = bit_addr >> LOG;
    acc_w     = acc_q;
    acc_w[bit_addr[LOG-1:0]] = bit_data;

    unique case (state_q)
      S_IDLE, S_ACCUM: begin
        if (bit_wren) begin
          if (bit_addr != exp_q) begin
            seq_d = 1'b1;
          end else begin
            exp_d = exp_q + 1'b1;
            if (bit_addr < CELLS_A) begin
              // last cell of a word, or of the world
              if (bit_addr[LOG-1:0] == TOP_B || bit_addr == LAST_A) begin
                push      = 1'b1;
                push_addr = cur_addr;
                push_data = acc_w;
                acc_d     = '0;
                part_d    = 1'b0;
              end else begin
                acc_d  = acc_w;
                part_d = 1'b1;
                wa_d   = cur_addr;
              end
            end
          end
        end
        if (load_finish) begin
          state_d = S_FLUSH;
        end else if (bit_wren) begin
          state_d = S_ACCUM;
        end
      end
      S_FLUSH: begin
        if (part_q) begin
          push      = 1'b1;
          push_addr = wa_q;
          push_data = acc_q;
        end
      end
      S_DONE: begin
        if (!load_finish) begin
          state_d = S_IDLE;
          exp_d   = '0;
          acc_d   = '0;
          part_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    push_ok = push && (!full || pop);
    if (push && !push_ok && state_q != S_FLUSH) begin
      ovf_d = 1'b1;
    end
    if (push_ok && state_q == S_FLUSH) begin
      acc_d  = '0;
      part_d = 1'b0;
    end

    f_addr_d = f_addr_q;
    f_data_d = f_data_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    if (push_ok) begin
      f_addr_d[wr_q] = push_addr;
      f_data_d[wr_q] = push_data;
      wr_d           = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop};

    // done once the partial word is out and the last word accepted
    if (state_q == S_FLUSH && !part_d && cnt_d == 2'd0) begin
      state_d = S_DONE;
    end
  end

  always_ff @(posedge clk_ram) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      exp_q       <= '0;
      acc_q       <= '0;
      part_q      <= 1'b0;
      wa_q        <= '0;
      ovf_q       <= 1'b0;
      seq_q       <= 1'b0;
      f_addr_q[0] <= '0;
      f_addr_q[1] <= '0;
      f_data_q[0] <= '0;
      f_data_q[1] <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      acc_q       <= acc_d;
      part_q      <= part_d;
      wa_q        <= wa_d;
      ovf_q       <= ovf_d;
      seq_q       <= seq_d;
      f_addr_q[0] <= f_addr_d[0];
      f_addr_q[1] <= f_addr_d[1];
      f_data_q[0] <= f_data_d[0];
      f_data_q[1] <= f_data_d[1];
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign word_valid = (cnt_q != 2'd0);
  assign word_addr  = word_valid ? f_addr_q[rd_q] : '0;
  assign word_data  = word_valid ? f_data_q[rd_q] : '0;
  assign load_done  = (state_q == S_DONE);
  assign overflow   = ovf_q;
  assign seq_error  = seq_q;

endmodule

// File: tb/tb_cell_word_packer.sv
// Directed bench for cell_word_packer; a 20x10 world keeps the
// end-of-world boundary reachable in a few hundred cycles.
module tb_cell_word_packer;

  localparam int AW = 24;
  localparam int WW = 32;

  logic          clk_ram = 1'b0;
  logic          reset;
  logic          bit_wren;
  logic          bit_data;
  logic [AW-1:0] bit_addr;
  logic          load_finish;
  logic          word_valid;
  logic          word_ready;
  logic [AW-1:0] word_addr;
  logic [WW-1:0] word_data;
  logic          load_done;
  logic          overflow;
  logic          seq_error;

  int n_chk = 0;
  int n_err = 0;

  logic [55:0] q[$];

  cell_word_packer #(
    .P_PARAM_W(20),
    .P_PARAM_H(10),
    .WORD_W(WW),
    .ADDR_W(AW)
  ) dut (
    .clk_ram(clk_ram),
    .reset(reset),
    .bit_wren(bit_wren),
    .bit_data(bit_data),
    .bit_addr(bit_addr),
    .load_finish(load_finish),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .word_addr(word_addr),
    .word_data(word_data),
    .load_done(load_done),
    .overflow(overflow),
    .seq_error(seq_error)
  );

  always #5 clk_ram = ~clk_ram;

  always @(posedge clk_ram) begin
    if (reset && word_valid && word_ready) begin
      q.push_back({word_addr, word_data});
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [55:0] qget(input int i);
    return (q.size() > i) ? q[i] : 56'hFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_ram);
      #1;
    end
  endtask

  task automatic send(input int a, input logic d);
    bit_wren = 1'b1;
    bit_addr = AW'(a);
    bit_data = d;
    tick(1);
    bit_wren = 1'b0;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    bit_wren    = 1'b0;
    load_finish = 1'b0;
    tick(1);
    reset = 1'b1;
    q.delete();
  endtask

  initial begin
    bit found;
    reset       = 1'b0;
    bit_wren    = 1'b0;
    bit_data    = 1'b0;
    bit_addr    = '0;
    load_finish = 1'b0;
    word_ready  = 1'b0;
    tick(2);

    chk("rst_valid", word_valid, 0);
    chk("rst_addr", word_addr, 0);
    chk("rst_data", word_data, 0);
    chk("rst_done", load_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_seq", seq_error, 0);

    // alternating stream, no backpressure
    do_reset();
    word_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      send(i, ~i[0]);
      if (i == 30) chk("t1_pre_valid", word_valid, 0);
      if (i == 31) begin
        chk("t1_valid", word_valid, 1);
        chk("t1_head", {word_addr, word_data}, {24'd0, 32'h5555_5555});
      end
    end
    tick(3);
    chk("t1_cnt", q.size(), 2);
    chk("t1_w0", qget(0), {24'd0, 32'h5555_5555});
    chk("t1_w1", qget(1), {24'd1, 32'h5555_5555});

    // stalled writer: two queued, third dropped
    do_reset();
    word_ready = 1'b0;
    for (int i = 0; i < 96; i++) begin
      send(i, ~i[0]);
      if (i == 94) chk("t2_no_ovf", overflow, 0);
    end
    chk("t2_ovf", overflow, 1);
    tick(4);
    chk("t2_hold", {word_valid, word_addr, word_data},
        {1'b1, 24'd0, 32'h5555_5555});
    word_ready = 1'b1;
    tick(4);
    chk("t2_cnt", q.size(), 2);
    chk("t2_w0", qget(0), {24'd0, 32'h5555_5555});
    chk("t2_w1", qget(1), {24'd1, 32'h5555_5555});
    chk("t2_empty", word_valid, 0);

    // partial word flushed on load_finish
    do_reset();
    word_ready = 1'b1;
    for (int i = 0; i < 40; i++) send(i, 1'b1);
    load_finish = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1);
      if (word_valid && word_addr == 24'd1) found = 1'b1;
    end
    chk("t3_found", found, 1);
    chk("t3_done_pre", load_done, 0);
    tick(1);
    chk("t3_done", load_done, 1);
    chk("t3_cnt", q.size(), 2);
    chk("t3_w0", qget(0), {24'd0, 32'hFFFF_FFFF});
    chk("t3_w1", qget(1), {24'd1, 32'h0000_00FF});
    load_finish = 1'b0;
    tick(1);
    chk("t3_rearm", load_done, 0);

    // out-of-sequence bit is dropped
    do_reset();
    word_ready = 1'b1;
    send(0, 1'b1);
    send(1, 1'b1);
    send(3, 1'b1);
    chk("t4_seq", seq_error, 1);
    send(2, 1'b1);
    send(3, 1'b0);
    for (int i = 4; i < 32; i++) send(i, 1'b1);
    tick(2);
    chk("t4_cnt", q.size(), 1);
    chk("t4_w0", qget(0), {24'd0, 32'hFFFF_FFF7});

    // end of world: cells 0..199, stream runs past it
    do_reset();
    word_ready = 1'b1;
    for (int i = 0; i < 210; i++) send(i, 1'b1);
    tick(3);
    chk("t5_cnt", q.size(), 7);
    chk("t5_w5", qget(5), {24'd5, 32'hFFFF_FFFF});
    chk("t5_w6", qget(6), {24'd6, 32'h0000_00FF});
    chk("t5_ovf", overflow, 0);
    chk("t5_seq", seq_error, 0);
    load_finish = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick(1);
      if (load_done) found = 1'b1;
    end
    chk("t5_done", found, 1);
    chk("t5_cnt2", q.size(), 7);

    // reset mid-word with a full FIFO
    do_reset();
    word_ready = 1'b0;
    for (int i = 0; i < 171; i++) send(i, 1'b1);
    chk("t6_ovf_pre", overflow, 1);
    do_reset();
    chk("t6_rst", {word_valid, word_addr, word_data,
                   load_done, overflow, seq_error}, 0);
    word_ready = 1'b1;
    for (int i = 0; i < 32; i++) send(i, i[1]);
    tick(2);
    chk("t6_cnt", q.size(), 1);
    chk("t6_w0", qget(0), {24'd0, 32'hCCCC_CCCC});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cell_word_packer.md
Name: cell_word_packer

Overview:
- Sits directly downstream of the SD file loader.
- Consumes the loader's serial one-bit-per-address cell stream (wren/data/address) and packs the bits into WORD_W-bit words.
- Hands each word to the world-memory writer over a valid/ready handshake, with a 2-entry word FIFO for backpressure.
- Flushes any partial word when the loader reports file completion, then raises load_done for the game engine.

Parameters:
- P_PARAM_W, 800, world width in cells
- P_PARAM_H, 600, world height in cells
- WORD_W, 32, packed word width (power of two, 8..64)
- ADDR_W, 24, bit-address width from loader; word_addr is bit_addr >> log2(WORD_W), same width

Ports:
- clk_ram  in  1  RAM-domain clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- bit_wren  in  1  loader bit strobe; one bit per asserted cycle
- bit_data  in  1  cell value for bit_addr
- bit_addr  in  ADDR_W  cell index of bit_data
- load_finish  in  1  loader file-complete level (high = file fully streamed)
- word_valid  out  1  word_data/word_addr valid
- word_ready  in  1  memory writer accepts word when valid&ready
- word_addr  out  ADDR_W  word index = cell index / WORD_W
- word_data  out  WORD_W  packed cells, bit i = cell word_addr*WORD_W+i (LSB = lowest cell)
- load_done  out  1  level: all words of the file accepted downstream
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full
- seq_error  out  1  sticky: bit_addr differed from the expected address; bit dropped

Behaviour:
- Reset (reset==0 at an edge): state IDLE; expected address 0; accumulator 0; FIFO empty; word_valid=0, word_addr=0, word_data=0, load_done=0, overflow=0, seq_error=0. Reset mid-stream discards all partial and queued data.
- CELLS = P_PARAM_W*P_PARAM_H (480000 by default).
- States:
  - IDLE: wait for data.
  - ACCUM: packing.
  - FLUSH: push partial word, drain FIFO.
  - DONE: hold load_done.
- IDLE -> ACCUM on the first bit_wren. IDLE -> FLUSH if load_finish=1 before any bit.
- Bit acceptance (IDLE/ACCUM, bit_wren=1):
  - If bit_addr != expected: set seq_error, drop the bit, expected unchanged.
  - Otherwise increment expected (ADDR_W wrap). If bit_addr < CELLS, write accumulator bit bit_addr[log2(WORD_W)-1:0]. Bits with bit_addr >= CELLS are consumed and discarded.
- Word completion: an accepted in-range bit with low bits == WORD_W-1, or == (CELLS-1) mod WORD_W at bit_addr==CELLS-1, pushes {addr, accumulator incl. this bit} to the FIFO. Accumulator clears in the same cycle.
- Push succeeds if FIFO not full, or if a pop happens in the same cycle. Otherwise set overflow and drop the word.
- Output: FIFO head drives word_valid/word_addr/word_data. word_valid asserts the cycle after a push into an empty FIFO (latency 1). Head is stable while valid&!ready; it advances on valid&ready.
- load_finish=1 in ACCUM -> FLUSH the next cycle. A bit arriving on the same cycle as load_finish rises is accepted first.
- FLUSH: if the accumulator holds a partial word (≥1 bit accepted since the last push), push it once, zero-padded. Retry each cycle while the FIFO is full; overflow is not set in FLUSH. Ignore bit_wren.
- FLUSH -> DONE when no partial word remains and the FIFO is empty.
- DONE: load_done=1 and bit_wren is ignored. On load_finish=0 (new file requested): clear load_done, expected=0, accumulator, go IDLE. overflow/seq_error persist until reset.
- word_ready is ignored while word_valid=0.

Test Plan:
- Stream 64 sequential bits addr 0..63, data alternating 1,0 starting 1, word_ready=1 -> words addr 0 and 1, each data 0x55555555; first word_valid the cycle after bit 31 is accepted.
- Same stream with word_ready=0 for 100 cycles -> 2 words queued. A third completed word (bits 64..95) sets overflow=1. After ready=1 exactly words 0 and 1 appear, unchanged while stalled.
- Stream bits 0..39 (all 1), then raise load_finish -> word 0 = 0xFFFFFFFF, word 1 = 0x000000FF. load_done=1 the cycle after word 1 is accepted.
- Send addr 0,1,3 -> seq_error=1, bit 3 dropped. Continue 2,3..31 -> word 0 completes normally with correct bits.
- Defaults, stream addr 479990..480010 after a valid prefix -> last word addr 14999 carries cells 479968..479999. Addresses ≥ 480000 produce no word; no overflow.
- Assert reset for 1 cycle midway through word 5 -> all outputs 0, FIFO empty. Restream from addr 0 -> word 0 is correct with no residue.
